conv_out_seq: RTL and testbench
===============================

# conv_out_seq

Parametrised output sequencer for the conv layers. A delayed per-group `in_valid` pulse from the compute block queues one result group of `NUM_CH` channels. The block then reads the output buffer one channel per cycle under downstream `out_ready` backpressure, tags each beat with channel and frame position, and reports pending overflow. It sits between the conv compute block/output buffer and the next layer or pooling stage.

## Interface
- `DELAY`, 2, cycles from `in_valid` to the queued-arrival pulse; ≥1.
- `NUM_CH`, 8, channels per result group; ≥2.
- `PEND_DEPTH`, 4, maximum queued groups; ≥1.
- `FRAME_GROUPS`, 16, groups per frame; ≥1.
- `CW` (local), = max(1, clog2(`NUM_CH`)); `PW` (local), = clog2(`PEND_DEPTH`+1).
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: reset, synchronous and active-low. It takes effect on the `clk` edge where `rst`=0.
- `in_valid` in 1: one-cycle pulse meaning one group is complete in the buffer.
- `out_ready` in 1: downstream accepts the current beat.
- `read_en` out 1: buffer read strobe. The buffer presents data one cycle later and holds it while `read_en`=0.
- `rd_ch` out CW: channel address paired with `read_en`.
- `output_valid` out 1: beat valid to downstream.
- `out_ch` out CW: channel index of the current beat.
- `out_last_ch` out 1: beat is channel `NUM_CH`-1.
- `out_last_frame` out 1: beat is the last channel of group `FRAME_GROUPS`-1.
- `pend_cnt` out PW: number of queued groups not yet fully read.
- `busy` out 1: delay line non-empty, or `pend_cnt`≠0, or state=READ, or `output_valid`.
- `overflow` out 1: sticky flag; an arrival was dropped.

## Operation
- **Delay line.** `DELAY`-stage shift register on `in_valid`; its last-stage output is `arrive`.
- **Free condition.** `free` = !`output_valid` | `out_ready`.
- **States.** FSM has two states, IDLE and READ.
  - IDLE → READ when `pend_cnt`≠0 or `arrive`=1.
  - In READ, `read_en` = `free` (combinational) and `rd_ch` = the channel counter.
- **Channel counter.** On `read_en` the channel counter increments. At `NUM_CH`-1 it wraps to 0 and the group completes (`grp_done`).
- **After a completed group.** Stay in READ if (`pend_cnt` − 1 + `arrive`) > 0; otherwise go to IDLE.
- **Pending counter.**
  - +1 on `arrive` and −1 on `grp_done`; both in the same cycle gives no change.
  - `arrive` with `pend_cnt`=`PEND_DEPTH` and no `grp_done` drops the arrival and sets `overflow`. `overflow` clears only on reset.
- **Frame counter.** 0..`FRAME_GROUPS`-1, increments on `grp_done`, wraps to 0.
- **Output register.**
  - On `read_en`: `output_valid`←1, `out_ch`←`rd_ch`, `out_last_ch`←(`rd_ch`=`NUM_CH`-1), `out_last_frame`←`out_last_ch` term & (frame cnt=`FRAME_GROUPS`-1).
  - Else if `out_ready`: `output_valid`←0.
  - While `output_valid`=1 and `out_ready`=0, every output holds stable and no read issues.
- **Reset values.** All outputs are 0: `read_en`, `rd_ch`, `output_valid`, `out_ch`, `out_last_ch`, `out_last_frame`, `pend_cnt`, `busy`, `overflow`. State=IDLE; delay line, channel and frame counters are 0.
- **Reset mid-operation.** Discards queued and in-flight groups; the frame restarts at group 0.

## Timing
- **Arrival.** `in_valid` at cycle 0 → `arrive` at cycle `DELAY`.
- **First beat.** READ at `DELAY`+1; first `read_en` at `DELAY`+1 (when `out_ready`=1); first `output_valid` at `DELAY`+2.
- **Throughput.** With `out_ready` held high: one beat per cycle, with no bubbles between back-to-back queued groups.
- **Backpressure.** `out_ready` low at cycle t with `output_valid`=1 → no `read_en` at t. Reads resume in the same cycle `out_ready` returns high.
- **Pending counter.** `pend_cnt` updates the cycle after `arrive`/`grp_done`.
- **`in_valid` spacing.** Pulses may arrive every cycle. Each pulse is a separate group, subject to `PEND_DEPTH`.

## Test plan
- **Single group.** Defaults, one `in_valid` pulse, `out_ready`=1 → `read_en` cycles 3–10 with `rd_ch` 0..7; `output_valid` cycles 4–11; `out_last_ch` only at cycle 11; `pend_cnt` returns to 0 at cycle 11.
- **Backpressure.** `out_ready`=0 for 3 cycles while `out_ch`=2 → `out_ch` holds 2, no `read_en`; beats 3..7 follow in order with no loss or duplicate.
- **Overflow.** 6 `in_valid` pulses on consecutive cycles with `out_ready`=0 → `pend_cnt` saturates at 4 and `overflow`=1. Release `out_ready` → exactly 32 beats, ending with `pend_cnt`=0 and `overflow` still 1.
- **Frame boundary.** `FRAME_GROUPS`=2, 3 groups → `out_last_frame` high only on the 16th beat; the 17th beat starts a new frame.
- **Reset mid-group.** `rst`=0 for one cycle during beat 4 → next cycle all outputs are 0, state IDLE, `pend_cnt`=0; a subsequent `in_valid` restarts at channel 0, frame group 0.
- **Simultaneous events.** `arrive` coincides with `grp_done` at `pend_cnt`=4 → no overflow, `pend_cnt` stays 4.

Source files
------------

// File: rtl/conv_out_seq.sv
// Output sequencer for conv layers: queues delayed group-complete pulses, then streams
// one channel per cycle from the output buffer under downstream backpressure.
module conv_out_seq #(
  parameter int DELAY        = 2,
  parameter int NUM_CH       = 8,
  parameter int PEND_DEPTH   = 4,
  parameter int FRAME_GROUPS = 16,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PW = $clog2(PEND_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          read_en,
  output logic [CW-1:0] rd_ch,
  output logic          output_valid,
  output logic [CW-1:0] out_ch,
  output logic          out_last_ch,
  output logic          out_last_frame,
  output logic [PW-1:0] pend_cnt,
  output logic          busy,
  output logic          overflow
);

  localparam int FW = (FRAME_GROUPS > 1) ? $clog2(FRAME_GROUPS) : 1;

  typedef enum logic {IDLE, READ} state_e;

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] ch;
    logic          last_ch;
    logic          last_frame;
  } beat_t;

  logic [DELAY-1:0] dly_q, dly_d;
  state_e           state_q, state_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [FW-1:0]    frm_q, frm_d;
  logic [PW-1:0]    pend_q, pend_d;
  logic             ovf_q, ovf_d;
  beat_t            beat_q, beat_d;

  logic arrive, free, rd, grp_done, ch_last, frm_last;

  generate
    if (DELAY == 1) begin : g_dly1
      assign dly_d = in_valid;
    end else begin : g_dlyn
      assign dly_d = {dly_q[DELAY-2:0], in_valid};
    end
  endgenerate

  assign arrive   = dly_q[DELAY-1];
  assign free     = !beat_q.vld || out_ready;
  assign ch_last  = (ch_q == CW'(NUM_CH - 1));
  assign frm_last = (frm_q == FW'(FRAME_GROUPS - 1));
  assign rd       = (state_q == READ) && free;
  assign grp_done = rd && ch_last;

  // A finished group keeps READ only if another queued group (or one landing now) remains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend_q != '0 || arrive) state_d = READ;
      READ:    if (grp_done && !(pend_q > PW'(1) || arrive)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_d  = ch_q;
    frm_d = frm_q;
    if (rd) ch_d = ch_last ? '0 : ch_q + 1'b1;
    if (grp_done) frm_d = frm_last ? '0 : frm_q + 1'b1;
  end

  // Arrival and completion together leave the count unchanged, even when full.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    case ({arrive, grp_done})
      2'b10: begin
        if (pend_q == PW'(PEND_DEPTH)) ovf_d = 1'b1;
        else                           pend_d = pend_q + 1'b1;
      end
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  always_comb begin
    beat_d = beat_q;
    if (rd) begin
      beat_d.vld        = 1'b1;
      beat_d.ch         = ch_q;
      beat_d.last_ch    = ch_last;
      beat_d.last_frame = ch_last && frm_last;
    end else if (out_ready) begin
      beat_d.vld = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dly_q   <= '0;
      state_q <= IDLE;
      ch_q    <= '0;
      frm_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      dly_q   <= dly_d;
      state_q <= state_d;
      ch_q    <= ch_d;
      frm_q   <= frm_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      beat_q  <= beat_d;
    end
  end

  assign read_en        = rd;
  assign rd_ch          = ch_q;
  assign output_valid   = beat_q.vld;
  assign out_ch         = beat_q.ch;
  assign out_last_ch    = beat_q.last_ch;
  assign out_last_frame = beat_q.last_frame;
  assign pend_cnt       = pend_q;
  assign overflow       = ovf_q;
  assign busy           = (|dly_q) || (pend_q != '0) || (state_q == READ) || beat_q.vld;

endmodule

// File: tb/tb_conv_out_seq.sv
// Directed + randomized bench for conv_out_seq; beats are scored against a group-level model.
module tb_conv_out_seq;
  localparam int DLY = 2;
  localparam int NCH = 8;
  localparam int PD  = 4;
  localparam int FG  = 2;
  localparam int CW  = 3;
  localparam int PW  = 3;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready;
  logic          read_en, output_valid, out_last_ch, out_last_frame, busy, overflow;
  logic [CW-1:0] rd_ch, out_ch;
  logic [PW-1:0] pend_cnt;

  conv_out_seq #(.DELAY(DLY), .NUM_CH(NCH), .PEND_DEPTH(PD), .FRAME_GROUPS(FG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .out_ready(out_ready),
    .read_en(read_en), .rd_ch(rd_ch), .output_valid(output_valid), .out_ch(out_ch),
    .out_last_ch(out_last_ch), .out_last_frame(out_last_frame), .pend_cnt(pend_cnt),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0, fails = 0;
  logic [CW+1:0] exp_q[$];
  int grp_idx = 0, beats = 0, lf_cnt = 0, first_lf = 0;
  logic prev_stall = 1'b0;
  logic [CW+2:0] prev_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: every accepted group yields channels 0..NCH-1; frame position is group index mod FG.
  task automatic push_group();
    for (int c = 0; c < NCH; c++)
      exp_q.push_back({CW'(c), c == NCH - 1, (c == NCH - 1) && (grp_idx % FG == FG - 1)});
    grp_idx++;
  endtask

  task automatic mon();
    logic [CW+1:0] e;
    if (prev_stall)
      chk("hold", {output_valid, out_ch, out_last_ch, out_last_frame}, prev_out);
    if (output_valid === 1'b1 && out_ready) begin
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", {out_ch, out_last_ch, out_last_frame}, e);
      end
      beats++;
      if (out_last_frame === 1'b1) begin
        lf_cnt++;
        if (first_lf == 0) first_lf = beats;
      end
    end
    if (output_valid === 1'b1 && !out_ready) begin
      chk("stall_noread", read_en, 0);
      prev_stall = 1'b1;
      prev_out   = {output_valid, out_ch, out_last_ch, out_last_frame};
    end else begin
      prev_stall = 1'b0;
    end
  endtask

  task automatic at_neg(); @(negedge clk); mon(); endtask
  task automatic pos();    @(posedge clk); #1;    endtask
  task automatic cyc();    at_neg(); pos();       endtask

  task automatic pulse();
    in_valid = 1'b1;
    push_group();
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    exp_q.delete();
    grp_idx = 0; beats = 0; lf_cnt = 0; first_lf = 0; prev_stall = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
      cyc();
      n++;
    end
    chk(tag, n < 3000, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    at_neg();
    chk("rst_outs", {read_en, rd_ch, output_valid, out_ch, out_last_ch, out_last_frame,
                     pend_cnt, busy, overflow}, 0);
    pos();
    rst = 1'b1;

    // Single group: reads at cycles 3..10, beats at 4..11
    in_valid = 1'b1;
    push_group();
    for (int k = 0; k <= 12; k++) begin
      at_neg();
      chk("sg_read_en", read_en, (k >= 3 && k <= 10));
      if (k >= 3 && k <= 10) chk("sg_rd_ch", rd_ch, k - 3);
      chk("sg_valid", output_valid, (k >= 4 && k <= 11));
      chk("sg_last_ch", output_valid && out_last_ch, k == 11);
      chk("sg_pend", pend_cnt, (k >= 3 && k <= 10) ? 1 : 0);
      pos();
      in_valid = 1'b0;
    end
    drain("sg_drain");
    chk("sg_beats", beats, 8);

    // Backpressure: hold while channel 2 is presented
    pulse();
    for (n = 0; n < 40; n++) begin
      at_neg();
      if (output_valid === 1'b1 && out_ready && out_ch == 1) break;
      pos();
    end
    chk("bp_found", n < 40, 1);
    pos();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("bp_ch", out_ch, 2);
      chk("bp_valid", output_valid, 1);
      chk("bp_noread", read_en, 0);
      pos();
    end
    out_ready = 1'b1;
    drain("bp_drain");
    chk("bp_beats", beats, 16);

    // Arrival coincides with group completion while full
    for (int k = 0; k < 4; k++) pulse();
    for (int k = 4; k < 8; k++) cyc();
    pulse();
    cyc();
    at_neg(); chk("sim_pend10", pend_cnt, 4); pos();
    at_neg(); chk("sim_pend11", pend_cnt, 4); chk("sim_ovf", overflow, 0); pos();
    drain("sim_drain");
    chk("sim_beats", beats, 56);

    // Randomized traffic, throttled so no arrival can be dropped
    for (int k = 0; k < 600; k++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if ((grp_idx - beats / NCH) < PD && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b1;
        push_group();
      end else begin
        in_valid = 1'b0;
      end
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("rnd_drain");
    chk("rnd_beats", beats, grp_idx * NCH);
    chk("rnd_ovf", overflow, 0);
    chk("rnd_pend", pend_cnt, 0);

    // Frame boundary: last_frame only on beat 16
    do_reset();
    for (int g = 0; g < 3; g++) begin
      pulse();
      for (int k = 0; k < 9; k++) cyc();
    end
    drain("frm_drain");
    chk("frm_beats", beats, 24);
    chk("frm_first_lf", first_lf, 16);
    chk("frm_lf_cnt", lf_cnt, 1);

    // Reset in the middle of a group that would end the frame
    pulse();
    for (n = 0; n < 40; n++) begin
      at_neg();
      if (output_valid === 1'b1 && out_ready && out_ch == 3) break;
      pos();
    end
    chk("rm_found", n < 40, 1);
    pos();
    do_reset();
    at_neg();
    chk("rm_outs", {read_en, rd_ch, output_valid, out_ch, out_last_ch, out_last_frame,
                    pend_cnt, busy, overflow}, 0);
    pos();
    pulse();
    drain("rm_drain");
    chk("rm_beats", beats, 8);
    chk("rm_lf_cnt", lf_cnt, 0);

    // Overflow: six back-to-back arrivals while stalled, four fit
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < PD) push_group();
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) cyc();
    at_neg();
    chk("ovf_pend", pend_cnt, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_hold_ch", {output_valid, out_ch}, {1'b1, 3'd0});
    pos();
    out_ready = 1'b1;
    drain("ovf_drain");
    chk("ovf_beats", beats, 32);
    chk("ovf_pend_end", pend_cnt, 0);
    chk("ovf_sticky", overflow, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
